// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 demultiplexer: select encodings and channel count.
package demux_pkg;

  localparam int unsigned DEMUX_N = 4;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

endpackage

// File: rtl/decoder2to4.sv
// Combinational 2-bit to 4-bit one-hot decoder; bit k is set when i_sel == k.
module decoder2to4
  import demux_pkg::*;
(
  input  logic [1:0]         i_sel,
  output logic [DEMUX_N-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    unique case (i_sel)
      SEL_A: o_onehot[0] = 1'b1;
      SEL_B: o_onehot[1] = 1'b1;
      SEL_C: o_onehot[2] = 1'b1;
      SEL_D: o_onehot[3] = 1'b1;
    endcase
  end

endmodule

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer: i_data is routed to the channel picked by i_sel,
// the other three channels are driven to zero; one clock of latency.
module demux_1to4
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_sel,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_b,
  output logic [DATA_W-1:0] o_c,
  output logic [DATA_W-1:0] o_d
);

  logic [DEMUX_N-1:0] en;

  decoder2to4 u_decoder (
    .i_sel    (i_sel),
    .o_onehot (en)
  );

  logic [DATA_W-1:0] a_d, b_d, c_d, d_d;
  logic [DATA_W-1:0] a_q, b_q, c_q, d_q;

  // Masking with the one-hot enable guarantees at most one non-zero channel.
  always_comb begin
    a_d = i_data & {DATA_W{en[0]}};
    b_d = i_data & {DATA_W{en[1]}};
    c_d = i_data & {DATA_W{en[2]}};
    d_d = i_data & {DATA_W{en[3]}};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      d_q <= d_d;
    end
  end

  assign o_a = a_q;
  assign o_b = b_q;
  assign o_c = c_q;
  assign o_d = d_q;

endmodule

// File: tb/tb_demux_1to4.sv
// Self-checking bench for demux_1to4: an 8-bit instance and a default-width instance
// share clock, reset and select; expected outputs go through a scoreboard queue.
module tb_demux_1to4;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic [1:0] sel;
  logic [7:0] o_a, o_b, o_c, o_d;
  logic       n_a, n_b, n_c, n_d;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Expected outputs packed as {d, c, b, a}, 8 bits per channel.
  logic [31:0] exp_q [$];

  typedef struct packed {
    logic [7:0]  data;
    logic [1:0]  sel;
    logic [31:0] exp;
  } vec_t;

  demux_1to4 #(.DATA_W(8)) dut8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (data),
    .i_sel   (sel),
    .o_a     (o_a),
    .o_b     (o_b),
    .o_c     (o_c),
    .o_d     (o_d)
  );

  demux_1to4 dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (data[0]),
    .i_sel   (sel),
    .o_a     (n_a),
    .o_b     (n_b),
    .o_c     (n_c),
    .o_d     (n_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] model(input logic [7:0] d, input logic [1:0] s);
    logic [31:0] r;
    r = '0;
    r[s*8 +: 8] = d;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called between edges: drive inputs, push expectation, compare just after the edge.
  task automatic step(input logic [7:0] d, input logic [1:0] s, input logic [31:0] exp,
                      input string name);
    logic [31:0] e;
    int          nz;
    data = d;
    sel  = s;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got empty scoreboard expected entry", name);
    end else begin
      e = exp_q.pop_front();
      check(name, {o_d, o_c, o_b, o_a}, e);
      check({name, "_w1"}, 32'({n_d, n_c, n_b, n_a}), 32'({e[24], e[16], e[8], e[0]}));
    end
    nz = int'(o_a != 0) + int'(o_b != 0) + int'(o_c != 0) + int'(o_d != 0);
    check({name, "_onehot"}, 32'(nz <= 1), 32'd1);
    @(negedge clk);
  endtask

  vec_t vecs [5];
  logic tog;

  initial begin
    vecs[0] = '{data: 8'hA5, sel: 2'd3, exp: {8'hA5, 8'h00, 8'h00, 8'h00}};
    vecs[1] = '{data: 8'hA5, sel: 2'd1, exp: {8'h00, 8'h00, 8'hA5, 8'h00}};
    vecs[2] = '{data: 8'h00, sel: 2'd2, exp: {8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{data: 8'hFF, sel: 2'd0, exp: {8'h00, 8'h00, 8'h00, 8'hFF}};
    vecs[4] = '{data: 8'h3C, sel: 2'd2, exp: {8'h00, 8'h3C, 8'h00, 8'h00}};

    rst_n = 1'b0;
    data  = 8'h01;
    sel   = 2'd2;

    // Reset held for 5 cycles with live inputs: everything stays zero.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", {o_d, o_c, o_b, o_a}, 32'h0);
      check("reset_hold_w1", 32'({n_d, n_c, n_b, n_a}), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h01, 2'd2, {8'h00, 8'h01, 8'h00, 8'h00}, "rst_release");

    // Select sweep with data toggling every cycle.
    tog = 1'b0;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 16; i++) begin
        tog = ~tog;
        step({7'h0, tog}, 2'(s), model({7'h0, tog}, 2'(s)), "sweep");
      end
    end

    // Wrap 3 -> 0.
    step(8'h01, 2'd3, {8'h01, 8'h00, 8'h00, 8'h00}, "wrap_pre");
    step(8'h01, 2'd0, {8'h00, 8'h00, 8'h00, 8'h01}, "wrap");
    check("wrap_o_d", 32'(o_d), 32'h0);
    check("wrap_o_a", 32'(o_a), 32'h1);

    // Mid-operation reset pulse between edges.
    step(8'h01, 2'd1, {8'h00, 8'h00, 8'h01, 8'h00}, "mid_pre");
    #1 rst_n = 1'b0;
    #1;
    check("async_clr_b", 32'(o_b), 32'h0);
    check("async_clr_all_w1", 32'({n_d, n_c, n_b, n_a}), 32'h0);
    #1 rst_n = 1'b1;
    #1;
    check("held_after_release", {o_d, o_c, o_b, o_a}, 32'h0);
    step(8'h01, 2'd1, {8'h00, 8'h00, 8'h01, 8'h00}, "mid_recover");

    // Wide-data table.
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].data, vecs[i].sel, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Random invariant run.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] d;
      logic [1:0] s;
      d = 8'($urandom);
      s = 2'($urandom_range(0, 3));
      step(d, s, model(d, s), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
